mux_scan_n: RTL and testbench
=============================

# mux_scan_n

Parametrised, registered N-channel multiplexer: the next generation of the team's 4-to-1 mux. It selects one WIDTH-bit channel from a packed input bus. It runs in one of two modes: fixed-select, or auto-scan with a programmable per-channel dwell time and a channel-enable mask. It sits in front of shared single-channel consumers (monitors, serialisers) that sample several sources in turn.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (>=1)
- N, 4, number of input channels (>=2; need not be a power of two)
- SEL_W, 2, select/channel-index width; must satisfy 2**SEL_W >= N
- DWELL_W, 4, dwell-count width

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_bus  input  N*WIDTH  packed channels; channel k = in_bus[k*WIDTH +: WIDTH]
- mode  input  1  0 = fixed select, 1 = auto-scan
- sel  input  SEL_W  channel index used in fixed mode
- enable_mask  input  N  per-channel enable, used in scan mode only
- dwell  input  DWELL_W  scan mode: cycles per channel = dwell+1
- out  output  WIDTH  registered selected data
- out_ch  output  SEL_W  index of the channel currently on out
- out_valid  output  1  out holds valid channel data
- wrap  output  1  one-cycle pulse when the scan wraps around

## Operation
- Internal state: FSM {IDLE, FIXED, SCAN}, current channel register ch, and dwell counter cnt (DWELL_W bits).
- Reset: state=IDLE; ch=0; cnt=0; out=0; out_ch=0; out_valid=0; wrap=0. All outputs are registers.
- IDLE: lasts one cycle after reset deasserts. Then goes to FIXED if mode=0, else SCAN. Outputs hold their reset values.
- FIXED, each cycle:
  - If sel<N: out<=channel sel, out_ch<=sel, out_valid<=1.
  - If sel>=N: out<=0, out_valid<=0, out_ch<=sel.
  - enable_mask and dwell are ignored.
- SCAN, each cycle:
  - If enable_mask==0: out<=0, out_valid<=0, ch and cnt hold, wrap<=0.
  - Else: out<=channel ch, out_ch<=ch, out_valid<=enable_mask[ch].
  - Advance when cnt==dwell or enable_mask[ch]==0: ch<=next enabled index after ch (circular search), cnt<=0. Otherwise cnt<=cnt+1.
  - On advance, wrap<=1 if the next index <= ch (this includes a single enabled channel advancing to itself). Otherwise wrap<=0.
- Mode change: takes effect on the next edge.
  - FIXED->SCAN: ch<=lowest enabled index (0 if mask empty), cnt<=0, wrap<=0.
  - SCAN->FIXED: ch and cnt are discarded.
- Mask or dwell change mid-dwell: takes effect immediately. If ch is disabled, it advances on the next edge. If cnt already exceeds the new dwell, the comparison treats cnt>=dwell as advance.
- reset has priority over every other input in every state.

## Timing
- Latency: out/out_ch/out_valid reflect in_bus, sel and ch sampled at the previous rising edge (1 cycle).
- Scan: each enabled channel appears on out for exactly dwell+1 consecutive cycles. Disabled channels take 0 output cycles; the circular search completes within one cycle.
- wrap is asserted for exactly one cycle, on the same edge that loads the wrapped ch. The wrapped channel's data appears on out the cycle after that.
- After reset deasserts, first valid output: 2 edges (IDLE, then the first FIXED/SCAN load).

## Test plan
- Fixed: N=4, WIDTH=8, in_bus={8'h44,8'h33,8'h22,8'h11}, mode=0. Step sel 0..3 every 2 cycles -> out=11,22,33,44 one cycle after each sel change; out_valid=1; out_ch tracks sel.
- Out-of-range: N=3, SEL_W=2, sel=3 -> out=0, out_valid=0.
- Scan: dwell=1, mask=4'b1111 -> out sequence 11,11,22,22,33,33,44,44,11,... The wrap pulse coincides with the edge that loads ch=0.
- Masked scan: mask=4'b1010, dwell=0 -> out alternates 22,44. wrap pulses on every load of ch=1.
- Mask changes: clear mask[ch] mid-dwell -> advance on the next edge. mask=0 -> out_valid=0 with ch held. Restore mask -> resume from the held ch.
- Reset mid-scan (cnt nonzero, wrap=1): assert reset for 1 cycle -> all outputs 0 at the next edge. The scan restarts at the lowest enabled channel after IDLE.

Source files
------------

// File: rtl/mux_scan_n.sv
// Registered N-channel multiplexer with fixed-select and auto-scan modes.
// Scan mode visits enabled channels in turn, holding each for dwell+1 cycles.
module mux_scan_n #(
  parameter int WIDTH   = 8,
  parameter int N       = 4,
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_bus,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic [N-1:0]         enable_mask,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [WIDTH-1:0]     out,
  output logic [SEL_W-1:0]     out_ch,
  output logic                 out_valid,
  output logic                 wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIXED = 2'd1,
    SCAN  = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [SEL_W-1:0]     ch_r;
  logic [SEL_W-1:0]     ch_nxt_s;
  logic [DWELL_W-1:0]   cnt_r;
  logic [DWELL_W-1:0]   cnt_nxt_s;
  logic [WIDTH-1:0]     out_nxt_s;
  logic [SEL_W-1:0]     out_ch_nxt_s;
  logic                 out_valid_nxt_s;
  logic                 wrap_nxt_s;
  logic [SEL_W-1:0]     scan_next_s;

  function automatic logic [WIDTH-1:0] chan_data(input logic [N*WIDTH-1:0] bus,
                                                 input logic [SEL_W-1:0]   idx);
    logic [N*WIDTH-1:0] shifted;
    shifted = bus >> (int'(idx) * WIDTH);
    return shifted[WIDTH-1:0];
  endfunction

  // Out-of-range indices read as disabled, so callers need no extra guard.
  function automatic logic is_enabled(input logic [N-1:0]     m,
                                      input logic [SEL_W-1:0] idx);
    logic [N-1:0] shifted;
    shifted = m >> idx;
    return shifted[0];
  endfunction

  function automatic logic [SEL_W-1:0] lowest_enabled(input logic [N-1:0] m);
    logic [SEL_W-1:0] res;
    res = {SEL_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (is_enabled(m, SEL_W'(i))) begin
        res = SEL_W'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Circular search starting one past cur; returns cur itself if it is the only one enabled.
  function automatic logic [SEL_W-1:0] next_enabled(input logic [SEL_W-1:0] cur,
                                                    input logic [N-1:0]     m);
    logic [SEL_W-1:0] res;
    logic             found;
    int               idx;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(cur) + i;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx;
      end
      if (!found && is_enabled(m, SEL_W'(idx))) begin
        res   = SEL_W'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return res;
  endfunction

  assign scan_next_s = next_enabled(ch_r, enable_mask);

  // Next-state and next-output logic for the mode FSM.
  always_comb begin
    state_nxt_s     = state_r;
    ch_nxt_s        = ch_r;
    cnt_nxt_s       = cnt_r;
    out_nxt_s       = out;
    out_ch_nxt_s    = out_ch;
    out_valid_nxt_s = out_valid;
    wrap_nxt_s      = 1'b0;
    case (state_r)
      IDLE: begin
        out_nxt_s       = {WIDTH{1'b0}};
        out_ch_nxt_s    = {SEL_W{1'b0}};
        out_valid_nxt_s = 1'b0;
        cnt_nxt_s       = {DWELL_W{1'b0}};
        if (mode) begin
          state_nxt_s = SCAN;
          ch_nxt_s    = lowest_enabled(enable_mask);
        end else begin
          state_nxt_s = FIXED;
        end
      end
      FIXED: begin
        out_ch_nxt_s = sel;
        if (int'(sel) < N) begin
          out_nxt_s       = chan_data(in_bus, sel);
          out_valid_nxt_s = 1'b1;
        end else begin
          out_nxt_s       = {WIDTH{1'b0}};
          out_valid_nxt_s = 1'b0;
        end
        if (mode) begin
          state_nxt_s = SCAN;
          ch_nxt_s    = lowest_enabled(enable_mask);
          cnt_nxt_s   = {DWELL_W{1'b0}};
        end else begin
          state_nxt_s = FIXED;
        end
      end
      SCAN: begin
        if (enable_mask == {N{1'b0}}) begin
          out_nxt_s       = {WIDTH{1'b0}};
          out_ch_nxt_s    = ch_r;
          out_valid_nxt_s = 1'b0;
        end else begin
          out_nxt_s       = chan_data(in_bus, ch_r);
          out_ch_nxt_s    = ch_r;
          out_valid_nxt_s = is_enabled(enable_mask, ch_r);
          // >= so that a shortened dwell releases a channel already past it.
          if ((cnt_r >= dwell) || !is_enabled(enable_mask, ch_r)) begin
            ch_nxt_s   = scan_next_s;
            cnt_nxt_s  = {DWELL_W{1'b0}};
            wrap_nxt_s = (scan_next_s <= ch_r);
          end else begin
            cnt_nxt_s  = cnt_r + {{(DWELL_W-1){1'b0}}, 1'b1};
          end
        end
        if (mode) begin
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = FIXED;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        ch_nxt_s        = {SEL_W{1'b0}};
        cnt_nxt_s       = {DWELL_W{1'b0}};
        out_nxt_s       = {WIDTH{1'b0}};
        out_ch_nxt_s    = {SEL_W{1'b0}};
        out_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, scan position and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      ch_r      <= {SEL_W{1'b0}};
      cnt_r     <= {DWELL_W{1'b0}};
      out       <= {WIDTH{1'b0}};
      out_ch    <= {SEL_W{1'b0}};
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ch_r      <= ch_nxt_s;
      cnt_r     <= cnt_nxt_s;
      out       <= out_nxt_s;
      out_ch    <= out_ch_nxt_s;
      out_valid <= out_valid_nxt_s;
      wrap      <= wrap_nxt_s;
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: expected output tuples are queued per clock
// edge and popped/compared one time unit after that edge.
module tb_mux_scan_n;

  logic        clock;
  logic        reset;
  logic [31:0] in_bus;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  enable_mask;
  logic [3:0]  dwell;
  logic [7:0]  out;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        wrap;

  logic [23:0] in_bus3;
  logic [1:0]  sel3;
  logic [2:0]  mask3;
  logic [7:0]  out3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        wrap3;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] c;
    logic       v;
    logic       w;
  } exp_t;

  exp_t sb[$];

  mux_scan_n #(.WIDTH(8), .N(4), .SEL_W(2), .DWELL_W(4)) dut (
    .clock(clock), .reset(reset), .in_bus(in_bus), .mode(mode), .sel(sel),
    .enable_mask(enable_mask), .dwell(dwell), .out(out), .out_ch(out_ch),
    .out_valid(out_valid), .wrap(wrap)
  );

  mux_scan_n #(.WIDTH(8), .N(3), .SEL_W(2), .DWELL_W(4)) dut3 (
    .clock(clock), .reset(reset), .in_bus(in_bus3), .mode(mode), .sel(sel3),
    .enable_mask(mask3), .dwell(dwell), .out(out3), .out_ch(out_ch3),
    .out_valid(out_valid3), .wrap(wrap3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] c, input logic v, input logic w);
    exp_t e;
    e.d = d; e.c = c; e.v = v; e.w = w;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("out", {24'd0, out}, {24'd0, e.d});
      chk("out_ch", {30'd0, out_ch}, {30'd0, e.c});
      chk("out_valid", {31'd0, out_valid}, {31'd0, e.v});
      chk("wrap", {31'd0, wrap}, {31'd0, e.w});
    end
  endtask

  task automatic tick_skip();
    @(posedge clock);
    #1;
  endtask

  initial begin
    in_bus      = 32'h44332211;
    in_bus3     = 24'h332211;
    mask3       = 3'b000;
    sel3        = 2'd3;
    reset       = 1'b1;
    mode        = 1'b0;
    sel         = 2'd0;
    enable_mask = 4'b0000;
    dwell       = 4'd0;

    // Reset, then IDLE cycle with outputs still at reset values.
    push(8'h00, 2'd0, 1'b0, 1'b0); tick();
    reset = 1'b0;
    push(8'h00, 2'd0, 1'b0, 1'b0); tick();

    // Fixed select: each channel two cycles.
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      push(8'(8'h11 * (s + 1)), 2'(s), 1'b1, 1'b0);
      push(8'(8'h11 * (s + 1)), 2'(s), 1'b1, 1'b0);
      tick(); tick();
      if (s == 0) begin
        chk("n3_oor_out", {24'd0, out3}, 32'h0);
        chk("n3_oor_valid", {31'd0, out_valid3}, 32'h0);
        chk("n3_oor_ch", {30'd0, out_ch3}, 32'd3);
        sel3 = 2'd2;
      end else if (s == 1) begin
        chk("n3_sel2_out", {24'd0, out3}, 32'h33);
        chk("n3_sel2_valid", {31'd0, out_valid3}, 32'h1);
      end
    end

    // FIXED -> SCAN: scan starts at lowest enabled channel.
    mode = 1'b1; enable_mask = 4'b0110; dwell = 4'd0;
    tick_skip();
    push(8'h22, 2'd1, 1'b1, 1'b0);
    push(8'h33, 2'd2, 1'b1, 1'b1);
    push(8'h22, 2'd1, 1'b1, 1'b0);
    tick(); tick(); tick();

    // Full scan, dwell=1.
    reset = 1'b1; enable_mask = 4'b1111; dwell = 4'd1;
    push(8'h00, 2'd0, 1'b0, 1'b0); tick();
    reset = 1'b0;
    push(8'h00, 2'd0, 1'b0, 1'b0); tick();
    push(8'h11, 2'd0, 1'b1, 1'b0); push(8'h11, 2'd0, 1'b1, 1'b0);
    push(8'h22, 2'd1, 1'b1, 1'b0); push(8'h22, 2'd1, 1'b1, 1'b0);
    push(8'h33, 2'd2, 1'b1, 1'b0); push(8'h33, 2'd2, 1'b1, 1'b0);
    push(8'h44, 2'd3, 1'b1, 1'b0); push(8'h44, 2'd3, 1'b1, 1'b1);
    push(8'h11, 2'd0, 1'b1, 1'b0); push(8'h11, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick();

    // Masked scan 1010, dwell=0.
    enable_mask = 4'b1010; dwell = 4'd0;
    push(8'h22, 2'd1, 1'b1, 1'b0); push(8'h44, 2'd3, 1'b1, 1'b1);
    push(8'h22, 2'd1, 1'b1, 1'b0); push(8'h44, 2'd3, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick();

    // Clear current channel mid-dwell, then empty mask, then restore.
    enable_mask = 4'b1111; dwell = 4'd3;
    push(8'h22, 2'd1, 1'b1, 1'b0); push(8'h22, 2'd1, 1'b1, 1'b0);
    tick(); tick();
    enable_mask = 4'b1101;
    push(8'h22, 2'd1, 1'b0, 1'b0); push(8'h33, 2'd2, 1'b1, 1'b0);
    tick(); tick();
    enable_mask = 4'b0000;
    push(8'h00, 2'd2, 1'b0, 1'b0); push(8'h00, 2'd2, 1'b0, 1'b0);
    tick(); tick();
    enable_mask = 4'b1111;
    push(8'h33, 2'd2, 1'b1, 1'b0); push(8'h33, 2'd2, 1'b1, 1'b0);
    push(8'h33, 2'd2, 1'b1, 1'b0); push(8'h44, 2'd3, 1'b1, 1'b0);
    push(8'h44, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();

    // Dwell shortened below the running count: advance at once.
    dwell = 4'd0;
    push(8'h44, 2'd3, 1'b1, 1'b1); push(8'h11, 2'd0, 1'b1, 1'b0);
    push(8'h22, 2'd1, 1'b1, 1'b0); push(8'h33, 2'd2, 1'b1, 1'b0);
    push(8'h44, 2'd3, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick();

    // Reset while wrap is high; scan restarts at lowest enabled channel.
    reset = 1'b1; enable_mask = 4'b1100; dwell = 4'd2;
    push(8'h00, 2'd0, 1'b0, 1'b0); tick();
    reset = 1'b0;
    push(8'h00, 2'd0, 1'b0, 1'b0); tick();
    push(8'h33, 2'd2, 1'b1, 1'b0); push(8'h33, 2'd2, 1'b1, 1'b0);
    push(8'h33, 2'd2, 1'b1, 1'b0); push(8'h44, 2'd3, 1'b1, 1'b0);
    push(8'h44, 2'd3, 1'b1, 1'b0); push(8'h44, 2'd3, 1'b1, 1'b1);
    push(8'h33, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) tick();

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
